// File: rtl/branch_predictor.sv
// Gshare/bimodal conditional-branch predictor with a 2-bit counter PHT, speculative and committed history.
// Define BPRED_GSHARE_EN to XOR the speculative history into the PHT index; the default build is bimodal.
module branch_predictor #(
  parameter int PATTERN_WIDTH  = 9,
  parameter int INST_MEM_WIDTH = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] target,
  output logic                      prediction,
  output logic [PATTERN_WIDTH-1:0]  pattern_out,
  output logic [INST_MEM_WIDTH-1:0] addr_on_failure_out,
  output logic [INST_MEM_WIDTH-1:0] next_pc,
  input  logic                      commit_valid,
  input  logic                      commit_failure,
  input  logic [PATTERN_WIDTH-1:0]  commit_pattern,
  input  logic [INST_MEM_WIDTH-1:0] commit_addr_on_failure,
  output logic                      redirect,
  output logic [INST_MEM_WIDTH-1:0] redirect_addr,
  output logic                      init_busy
);

  localparam int IDX_W     = PATTERN_WIDTH - 1;
  localparam int PHT_DEPTH = 1 << IDX_W;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_idx;
  logic [IDX_W-1:0] ghr_spec;
  logic [IDX_W-1:0] ghr_arch;
  logic [IDX_W-1:0] ghr_arch_next;

  logic [1:0]       pht [PHT_DEPTH];
  logic             pht_we;
  logic [IDX_W-1:0] pht_waddr;
  logic [1:0]       pht_wdata;

  logic [IDX_W-1:0] lookup_idx;
  logic [1:0]       lookup_cnt;
  logic [INST_MEM_WIDTH-1:0] pc_plus1;

  logic             run;
  logic             accept;
  logic             commit_fire;
  logic             actual;
  logic [IDX_W-1:0] commit_idx;
  logic [1:0]       commit_cnt;
  logic [1:0]       commit_cnt_new;

  // ---------------------------------------------------------------- FSM
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_idx == IDX_W'(PHT_DEPTH - 1)) begin
      state_d = RUN;
    end
  end

  assign run       = (state_q == RUN);
  assign init_busy = (state_q == INIT);

  // ---------------------------------------------------------------- lookup
`ifdef BPRED_GSHARE_EN
  assign lookup_idx = ghr_spec ^ pc[IDX_W-1:0];
`else
  assign lookup_idx = pc[IDX_W-1:0];
`endif

  assign lookup_cnt  = pht[lookup_idx];
  assign prediction  = lookup_cnt[1];
  assign pattern_out = {lookup_idx, prediction};
  assign pc_plus1    = pc + INST_MEM_WIDTH'(1);

  always_comb begin
    next_pc             = pc_plus1;
    addr_on_failure_out = target;
    if (prediction) begin
      next_pc             = target;
      addr_on_failure_out = pc_plus1;
    end
  end

  // ---------------------------------------------------------------- commit
  assign commit_fire    = commit_valid && run;
  assign actual         = commit_pattern[0] ^ commit_failure;
  assign commit_idx     = commit_pattern[PATTERN_WIDTH-1:1];
  assign commit_cnt     = pht[commit_idx];
  assign ghr_arch_next  = {ghr_arch[IDX_W-2:0], actual};

  always_comb begin
    commit_cnt_new = commit_cnt;
    if (actual && commit_cnt != 2'b11) begin
      commit_cnt_new = commit_cnt + 2'b01;
    end else if (!actual && commit_cnt != 2'b00) begin
      commit_cnt_new = commit_cnt - 2'b01;
    end
  end

  assign redirect      = commit_fire && commit_failure;
  assign redirect_addr = commit_addr_on_failure;
  assign req_ready     = run && !redirect;
  assign accept        = req_valid && req_ready;

  // Single PHT write port: initialisation fill in INIT, counter training in RUN.
  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = commit_idx;
    pht_wdata = commit_cnt_new;
    if (state_q == INIT) begin
      pht_we    = 1'b1;
      pht_waddr = init_idx;
      pht_wdata = 2'b01;
    end else if (commit_fire) begin
      pht_we = 1'b1;
    end
  end

  // NOTE: the PHT array has no reset; the INIT sweep gives it defined contents instead.
  always_ff @(posedge clk) begin
    if (pht_we) begin
      pht[pht_waddr] <= pht_wdata;
    end
  end

  // ---------------------------------------------------------------- state
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INIT;
      init_idx <= '0;
      ghr_spec <= '0;
      ghr_arch <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        init_idx <= init_idx + IDX_W'(1);
      end
      if (commit_fire) begin
        ghr_arch <= ghr_arch_next;
      end
      // A misprediction squashes all younger speculation, so history restarts from the committed view.
      if (redirect) begin
        ghr_spec <= ghr_arch_next;
      end else if (accept) begin
        ghr_spec <= {ghr_spec[IDX_W-2:0], prediction};
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor: init timing, lookup table, commit/redirect corner cases.
module tb_branch_predictor;

`ifdef BPRED_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] pc;
  logic [14:0] target;
  logic        prediction;
  logic [8:0]  pattern_out;
  logic [14:0] addr_on_failure_out;
  logic [14:0] next_pc;
  logic        commit_valid;
  logic        commit_failure;
  logic [8:0]  commit_pattern;
  logic [14:0] commit_addr_on_failure;
  logic        redirect;
  logic [14:0] redirect_addr;
  logic        init_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.PATTERN_WIDTH(9), .INST_MEM_WIDTH(15)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .pc                     (pc),
    .target                 (target),
    .prediction             (prediction),
    .pattern_out            (pattern_out),
    .addr_on_failure_out    (addr_on_failure_out),
    .next_pc                (next_pc),
    .commit_valid           (commit_valid),
    .commit_failure         (commit_failure),
    .commit_pattern         (commit_pattern),
    .commit_addr_on_failure (commit_addr_on_failure),
    .redirect               (redirect),
    .redirect_addr          (redirect_addr),
    .init_busy              (init_busy)
  );

  typedef struct {
    logic [14:0] pc;
    logic [14:0] target;
    logic        pred;
    logic [14:0] next_pc;
    logic [14:0] aof;
    logic [8:0]  pattern;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int bad_ready;
    int bad_redir;
    logic [1:0] sat_exp [5];

    // Fresh PHT: all counters weakly not-taken, history zero, so every lookup predicts not taken.
    vecs[0] = '{pc: 15'h0010, target: 15'h0200, pred: 1'b0, next_pc: 15'h0011, aof: 15'h0200, pattern: 9'h020};
    vecs[1] = '{pc: 15'h7FFF, target: 15'h0123, pred: 1'b0, next_pc: 15'h0000, aof: 15'h0123, pattern: 9'h1FE};
    vecs[2] = '{pc: 15'h1234, target: 15'h0ABC, pred: 1'b0, next_pc: 15'h1235, aof: 15'h0ABC, pattern: 9'h068};
    vecs[3] = '{pc: 15'h0000, target: 15'h7FFF, pred: 1'b0, next_pc: 15'h0001, aof: 15'h7FFF, pattern: 9'h000};
    vecs[4] = '{pc: 15'h5A81, target: 15'h0040, pred: 1'b0, next_pc: 15'h5A82, aof: 15'h0040, pattern: 9'h102};
    sat_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2};

    reset = 1'b1;
    req_valid = 1'b0;
    pc = '0;
    target = '0;
    commit_valid = 1'b0;
    commit_failure = 1'b0;
    commit_pattern = '0;
    commit_addr_on_failure = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_init_busy", 32'(init_busy), 32'd1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);

    // Partial init, then a second reset must restart the sweep from index 0.
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_init_busy", 32'(init_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Count INIT cycles while a failing commit is offered; it must be ignored.
    cnt = 0;
    bad_ready = 0;
    bad_redir = 0;
    commit_pattern = 9'h1FF;
    commit_addr_on_failure = 15'h4444;
    while (init_busy === 1'b1 && cnt < 1000) begin
      commit_valid = (cnt < 200);
      commit_failure = (cnt < 200);
      #1;
      if (req_ready !== 1'b0) bad_ready++;
      if (redirect !== 1'b0) bad_redir++;
      cnt++;
      @(negedge clk);
    end
    commit_valid = 1'b0;
    commit_failure = 1'b0;
    #1;
    check("init_cycles", 32'(cnt), 32'd256);
    check("init_ready_low", 32'(bad_ready), 32'd0);
    check("init_no_redirect", 32'(bad_redir), 32'd0);
    check("run_init_busy", 32'(init_busy), 32'd0);
    check("run_req_ready", 32'(req_ready), 32'd1);
    check("init_ghr_arch", 32'(dut.ghr_arch), 32'd0);

    // Table-driven lookups, each accepted (all predict not taken, history stays zero).
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pc = vecs[i].pc;
      target = vecs[i].target;
      req_valid = 1'b1;
      #1;
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
      check($sformatf("v%0d_pred", i), 32'(prediction), 32'(vecs[i].pred));
      check($sformatf("v%0d_next_pc", i), 32'(next_pc), 32'(vecs[i].next_pc));
      check($sformatf("v%0d_aof", i), 32'(addr_on_failure_out), 32'(vecs[i].aof));
      check($sformatf("v%0d_pattern", i), 32'(pattern_out), 32'(vecs[i].pattern));
    end
    @(negedge clk);
    req_valid = 1'b0;

    // Mispredicted commit of the pc=0x10 lookup: actual taken, redirect to 0x200.
    commit_valid = 1'b1;
    commit_failure = 1'b1;
    commit_pattern = 9'h020;
    commit_addr_on_failure = 15'h0200;
    #1;
    check("mis_redirect", 32'(redirect), 32'd1);
    check("mis_redirect_addr", 32'(redirect_addr), 32'h0200);
    check("mis_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    commit_valid = 1'b0;
    commit_failure = 1'b0;
    pc = 15'h0010;
    target = 15'h0200;
    req_valid = 1'b1;
    #1;
    check("mis_after_redirect", 32'(redirect), 32'd0);
    check("mis_ghr_spec", 32'(dut.ghr_spec), 32'h01);
    check("mis_ghr_arch", 32'(dut.ghr_arch), 32'h01);
    check("mis_cnt10", 32'(dut.pht[8'h10]), 32'd2);
    check("mis_relookup_pred", 32'(prediction), GS ? 32'd0 : 32'd1);
    check("mis_relookup_pattern", 32'(pattern_out), GS ? 32'h022 : 32'h021);
    check("mis_relookup_next_pc", 32'(next_pc), GS ? 32'h0011 : 32'h0200);
    req_valid = 1'b0;

    // Saturation at index 0x10: four taken commits then one not-taken.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      commit_valid = 1'b1;
      commit_failure = 1'b0;
      commit_pattern = (i < 4) ? 9'h021 : 9'h020;
      @(negedge clk);
      commit_valid = 1'b0;
      pc = 15'h0010;
      req_valid = 1'b1;
      #1;
      check($sformatf("sat%0d_cnt", i), 32'(dut.pht[8'h10]), 32'(sat_exp[i]));
      check($sformatf("sat%0d_pred", i), 32'(prediction), GS ? 32'd0 : 32'd1);
      req_valid = 1'b0;
    end
    check("sat_ghr_arch", 32'(dut.ghr_arch), 32'h3E);

    // Failing commit with a same-cycle request: request refused, history restored.
    @(negedge clk);
    commit_valid = 1'b1;
    commit_failure = 1'b1;
    commit_pattern = 9'h041;
    commit_addr_on_failure = 15'h0333;
    pc = 15'h0020;
    req_valid = 1'b1;
    #1;
    check("fc_req_ready", 32'(req_ready), 32'd0);
    check("fc_redirect", 32'(redirect), 32'd1);
    check("fc_redirect_addr", 32'(redirect_addr), 32'h0333);
    @(negedge clk);
    commit_valid = 1'b0;
    commit_failure = 1'b0;
    req_valid = 1'b0;
    #1;
    check("fc_ghr_arch", 32'(dut.ghr_arch), 32'h7C);
    check("fc_ghr_spec", 32'(dut.ghr_spec), 32'h7C);
    check("fc_cnt20", 32'(dut.pht[8'h20]), 32'd0);

    // Non-failing commit and lookup hitting index 0x40 in the same cycle.
    @(negedge clk);
    commit_valid = 1'b1;
    commit_failure = 1'b0;
    commit_pattern = 9'h081;
    pc = 15'(8'h40 ^ (GS ? 8'h7C : 8'h00));
    req_valid = 1'b1;
    #1;
    check("bp_req_ready", 32'(req_ready), 32'd1);
    check("bp_redirect", 32'(redirect), 32'd0);
    check("bp_old_pred", 32'(prediction), 32'd0);
    check("bp_old_pattern", 32'(pattern_out), 32'h080);
    @(negedge clk);
    commit_valid = 1'b0;
    pc = 15'(8'h40 ^ (GS ? 8'hF8 : 8'h00));
    #1;
    check("bp_ghr_spec", 32'(dut.ghr_spec), 32'hF8);
    check("bp_new_pred", 32'(prediction), 32'd1);
    check("bp_new_pattern", 32'(pattern_out), 32'h081);
    req_valid = 1'b0;

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PATTERN_WIDTH, default 9: bits 8:1 hold the PHT index and bit 0 holds the predicted direction.
REQ-002 SHALL have parameter INST_MEM_WIDTH, default 15: word-address width of instruction memory.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: decode presents a conditional branch needing a prediction.
REQ-006 SHALL have port req_ready, output, 1: prediction accepted this cycle.
REQ-007 SHALL have port pc, input, INST_MEM_WIDTH: branch address.
REQ-008 SHALL have port target, input, INST_MEM_WIDTH: taken target.
REQ-009 SHALL have port prediction, output, 1: predicted taken.
REQ-010 SHALL have port pattern_out, output, PATTERN_WIDTH: {PHT index, prediction}, stored by the branch unit.
REQ-011 SHALL have port addr_on_failure_out, output, INST_MEM_WIDTH: fetch address if the prediction is wrong.
REQ-012 SHALL have port next_pc, output, INST_MEM_WIDTH: predicted fetch address.
REQ-013 SHALL have port commit_valid, input, 1: the oldest branch commits.
REQ-014 SHALL have port commit_failure, input, 1: the committed branch was mispredicted.
REQ-015 SHALL have port commit_pattern, input, PATTERN_WIDTH: pattern returned with the committed branch.
REQ-016 SHALL have port commit_addr_on_failure, input, INST_MEM_WIDTH: recovery address returned with the committed branch.
REQ-017 SHALL have port redirect, output, 1: flush and refetch request.
REQ-018 SHALL have port redirect_addr, output, INST_MEM_WIDTH: refetch address.
REQ-019 SHALL have port init_busy, output, 1: PHT initialisation in progress.

Function
REQ-020 SHALL hold a PHT of 2**(PATTERN_WIDTH-1) 2-bit saturating counters, one write per cycle, with combinational read.
REQ-021 SHALL hold speculative history ghr_spec and committed history ghr_arch, each PATTERN_WIDTH-1 bits.
REQ-022 SHALL use FSM states INIT and RUN: INIT writes 2'b01 to entry init_idx and increments init_idx each cycle, moving to RUN after the last entry (N cycles); init_busy=1 only in INIT.
REQ-023 SHALL compute index = ghr_spec XOR pc[PATTERN_WIDTH-2:0], and prediction = PHT[index][1].
REQ-024 SHALL drive pattern_out={index,prediction}; when predicted taken, next_pc=target and addr_on_failure_out=pc+1; when not taken, the two are swapped; pc+1 wraps modulo 2**INST_MEM_WIDTH.
REQ-025 SHALL set req_ready = RUN && !redirect; on acceptance, ghr_spec <= {ghr_spec[PATTERN_WIDTH-3:0],prediction}.
REQ-026 SHALL, on commit_valid in RUN, take actual = commit_pattern[0]^commit_failure, then saturating-increment (actual=1) or decrement (actual=0) PHT[commit_pattern[PATTERN_WIDTH-1:1]], and shift actual into ghr_arch.
REQ-027 SHALL drive redirect = commit_valid && commit_failure && RUN combinationally, with redirect_addr = commit_addr_on_failure.
REQ-028 SHALL, on a failing commit, load ghr_spec with the updated ghr_arch value; any same-cycle request is not accepted.
REQ-029 SHALL, on a non-failing commit plus an accepted request in the same cycle, perform both updates; a lookup of the index being written returns the old counter, and the new value is visible the next cycle.
REQ-030 SHALL ignore commit_valid during INIT; outputs other than init_busy, req_ready and redirect are don't-care while req_valid=0.

Reset
REQ-031 SHALL, on reset, enter INIT with init_idx=0 and ghr_spec=ghr_arch=0; reset during INIT restarts at index 0.
REQ-032 SHALL hold reset output values of init_busy=1, req_ready=0 and redirect=0; PHT contents are defined only after INIT completes.

Configuration
REQ-033 SHALL, when BPRED_GSHARE_EN is defined, index as in REQ-023; without it, index = pc[PATTERN_WIDTH-2:0] (bimodal), with histories still maintained but unused for indexing.

Verification
REQ-034 SHALL verify reset pulse -> init_busy=1 and req_ready=0 for exactly 256 cycles, then the first lookup gives prediction=0.
REQ-035 SHALL verify, after init, pc=0x0010 and target=0x0200 -> prediction=0, next_pc=0x0011, addr_on_failure_out=0x0200, pattern_out={0x10,0}; committing that pattern with failure=1 -> redirect=1, redirect_addr=0x0200, and the next lookup at pc=0x0010 (ghr_spec=0x01, index 0x11) uses an untouched counter.
REQ-036 SHALL verify saturation (bimodal build): four taken commits to index 0x10 then one not-taken -> counter 3,3,3,3,2 with prediction staying 1.
REQ-037 SHALL verify req_valid=1 in the same cycle as a failing commit -> req_ready=0, and ghr_spec equals the updated ghr_arch next cycle.
REQ-038 SHALL verify a non-failing commit and a lookup to the same index in one cycle -> the lookup sees the old counter and the following cycle sees the new one.
REQ-039 SHALL verify pc=0x7FFF, predicted not taken -> next_pc=0x0000.
